// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one forward round key per cycle, then one inverse round per cycle.
// Optional round-key cache (skips key expansion for a repeated key) enabled by defining AES_DEC_KEYCACHE_EN.
module aes_decrypt_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] datain,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dataout
);

  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, DONE} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] t;
    t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t         state_reg, state_next;
  logic [3:0]     round_reg;
  logic [127:0]   blk_reg;
  logic [127:0]   rk_reg [0:10];
  logic           accept;
  logic           cache_hit;

  logic [3:0]     prev_idx;
  logic [127:0]   prev_key;
  logic [31:0]    rot_word, sub_word, temp_word;
  logic [31:0]    w0_next, w1_next, w2_next, w3_next;
  logic [127:0]   rk_new;

  logic [127:0]   sub_vec, shift_vec, ark_vec, mix_vec, round_out;

  assign accept   = in_valid && in_ready;
  assign in_ready = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign dataout  = out_valid ? blk_reg : 128'd0;

`ifdef AES_DEC_KEYCACHE_EN
  logic cache_valid_reg;

  // rk_reg[0] doubles as the cached key tag; the rest of the array is the cached schedule.
  assign cache_hit = cache_valid_reg && (key == rk_reg[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid_reg <= 1'b0;
    end else if (state_reg == IDLE && accept) begin
      cache_valid_reg <= cache_hit;
    end else if (state_reg == KEYEXP && round_reg == 4'd10) begin
      cache_valid_reg <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // Forward key schedule step from the previous round key.
  assign prev_idx  = (round_reg == 4'd0) ? 4'd0 : round_reg - 4'd1;
  assign prev_key  = rk_reg[prev_idx];
  assign rot_word  = {prev_key[23:0], prev_key[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
      assign sub_word[31-8*gi -: 8] = sbox(rot_word[31-8*gi -: 8]);
    end
  endgenerate

  assign temp_word = sub_word ^ {rcon_of(round_reg), 24'h000000};
  assign w0_next   = prev_key[127:96] ^ temp_word;
  assign w1_next   = prev_key[95:64]  ^ w0_next;
  assign w2_next   = prev_key[63:32]  ^ w1_next;
  assign w3_next   = prev_key[31:0]   ^ w2_next;
  assign rk_new    = {w0_next, w1_next, w2_next, w3_next};

  // InvSubBytes is bytewise, so it is applied before the InvShiftRows permutation.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_inv_sub
      localparam int SRC = 4 * (((gi / 4) - (gi % 4) + 4) % 4) + (gi % 4);
      assign sub_vec[127-8*gi -: 8]   = inv_sbox(blk_reg[127-8*gi -: 8]);
      assign shift_vec[127-8*gi -: 8] = sub_vec[127-8*SRC -: 8];
    end
  endgenerate

  assign ark_vec = shift_vec ^ rk_reg[round_reg];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_inv_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = ark_vec[127-32*gi -: 8];
      assign a1 = ark_vec[119-32*gi -: 8];
      assign a2 = ark_vec[111-32*gi -: 8];
      assign a3 = ark_vec[103-32*gi -: 8];
      assign mix_vec[127-32*gi -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      assign mix_vec[119-32*gi -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      assign mix_vec[111-32*gi -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      assign mix_vec[103-32*gi -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
  endgenerate

  assign round_out = (round_reg != 4'd0) ? mix_vec : ark_vec;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = cache_hit ? INIT : KEYEXP;
      KEYEXP:  if (round_reg == 4'd10) state_next = INIT;
      INIT:    state_next = ROUND;
      ROUND:   if (round_reg == 4'd0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round_reg <= 4'd0;
      blk_reg   <= 128'd0;
      for (int i = 0; i < 11; i++) rk_reg[i] <= 128'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            blk_reg   <= datain;
            rk_reg[0] <= key;
            round_reg <= 4'd1;
          end
        end
        KEYEXP: begin
          rk_reg[round_reg] <= rk_new;
          round_reg         <= round_reg + 4'd1;
        end
        INIT: begin
          blk_reg   <= blk_reg ^ rk_reg[10];
          round_reg <= 4'd9;
        end
        ROUND: begin
          blk_reg <= round_out;
          if (round_reg != 4'd0) round_reg <= round_reg - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: known vectors, backpressure, mid-round reset, and random
// round trips against a table-driven AES-128 encrypt model kept in the bench.
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] datain;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dataout;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox_tbl [256];
  logic [127:0] c_key;
  logic         c_valid;

  always #5 clk = ~clk;

  aes_decrypt_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .datain    (datain),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataout   (dataout)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box built by walking the multiplicative group with generator 3.
  task automatic init_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tbl[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tbl[0] = 8'h63;
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_tbl[tmp[23:16]], sbox_tbl[tmp[15:8]], sbox_tbl[tmp[7:0]], sbox_tbl[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_tbl[s[i]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) s[4*c+j] = t[4*((c+j)%4)+j];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Expected accept-to-out_valid latency, tracking the key cache at transaction level.
  function automatic int next_latency(input logic [127:0] k);
    int lat;
    lat = 21;
`ifdef AES_DEC_KEYCACHE_EN
    if (c_valid && k == c_key) lat = 11;
    c_valid = 1'b1;
    c_key   = k;
`endif
    return lat;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_dec(input string tag, input logic [127:0] k, input logic [127:0] ct,
                        input logic [127:0] exp_pt, input bit backpressure);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, " in_ready before accept"}, in_ready, 1);
    lat      = next_latency(k);
    in_valid = 1'b1;
    key      = k;
    datain   = ct;
    tick();
    in_valid = 1'b0;
    key      = rand128();
    datain   = rand128();
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, " latency"}, n, lat);
    check({tag, " dataout"}, dataout, exp_pt);
    if (backpressure) begin
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'b1;
        datain   = rand128();
        key      = rand128();
        tick();
        check({tag, " bp dataout stable"}, dataout, exp_pt);
        check({tag, " bp in_ready low"}, in_ready, 0);
        check({tag, " bp out_valid held"}, out_valid, 1);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " idle in_ready"}, in_ready, 1);
    check({tag, " idle out_valid"}, out_valid, 0);
    check({tag, " idle dataout zero"}, dataout, 128'd0);
    $display("txn %s key=%h ct=%h pt=%h lat=%0d", tag, k, ct, exp_pt, n);
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    logic [127:0] rk, rp, rc;
    init_sbox();
    c_valid   = 1'b0;
    c_key     = 128'd0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    datain    = 128'd0;
    key       = 128'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset dataout", dataout, 128'd0);

    do_dec("fips_c1", K1, C1, P1, 1'b0);
    do_dec("fips_c1_again", K1, C1, P1, 1'b0);
    do_dec("fips_b", K2, C2, P2, 1'b0);
    do_dec("backpressure", K1, C1, P1, 1'b1);

    // Reset pulse sampled on the edge that ends the 7th ROUND cycle.
    check("rst_mid in_ready", in_ready, 1);
    in_valid = 1'b1;
    key      = K2;
    datain   = C2;
    tick();
    in_valid = 1'b0;
    repeat (17) tick();
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    c_valid = 1'b0;
    check("rst_mid in_ready", in_ready, 1);
    check("rst_mid out_valid", out_valid, 0);
    check("rst_mid dataout", dataout, 128'd0);
    do_dec("after_rst", K1, C1, P1, 1'b0);

    rk = rand128();
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3) != 0) rk = rand128();
      rp = rand128();
      rc = ref_encrypt(rp, rk);
      do_dec("rand", rk, rc, rp, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
